// File: rtl/weightmem_banked_pkg.sv
// Shared parameters and types for the banked OCU weight store.
// Default geometry: 4 banks x 32 words x 32 bits (20 trits packed 5-per-byte).
package weightmem_banked_pkg;

  localparam int unsigned N_O             = 4;
  localparam int unsigned N_I             = 40;
  localparam int unsigned WEIGHT_STAGGER  = 2;
  localparam int unsigned WEIGHTBANKDEPTH = 32;

  localparam int unsigned WEIGHTMEM_FIFO_DEPTH = 2;
  localparam int unsigned WEIGHTMEM_DATA_WIDTH = ((N_I / WEIGHT_STAGGER + 4) / 5) * 8;
  localparam int unsigned WEIGHTMEM_AW         = $clog2(WEIGHTBANKDEPTH);
  localparam int unsigned WEIGHTMEM_BW         = WEIGHTMEM_DATA_WIDTH / 8;

  typedef logic [WEIGHTMEM_AW-1:0]         weightmem_addr_t;
  typedef logic [WEIGHTMEM_DATA_WIDTH-1:0] weightmem_word_t;
  typedef logic [WEIGHTMEM_BW-1:0]         weightmem_be_t;

  // Even parity: the stored bit makes the byte plus parity have an even number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/weightmem_rd_fifo.sv
// Small read-return FIFO with occupancy output; one per bank.
// Storage is not reset, only pointers and count.
module weightmem_rd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] slot [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot[wptr] <= push_data;
  end

  assign pop_data = slot[rptr];
  assign valid    = (count != '0);

endmodule

// File: rtl/weightmem_banked.sv
// Banked weight SRAM: one shared byte-enabled write port, one buffered read channel per bank.
// Define WEIGHTMEM_PARITY_EN to store and check one even-parity bit per byte.
module weightmem_banked
  import weightmem_banked_pkg::*;
#(
  parameter int unsigned N_BANKS    = N_O,
  parameter int unsigned NUM_WORDS  = WEIGHTBANKDEPTH,
  parameter int unsigned DATA_WIDTH = WEIGHTMEM_DATA_WIDTH,
  parameter int unsigned AW         = $clog2(NUM_WORDS),
  parameter int unsigned BW         = DATA_WIDTH / 8,
  localparam int unsigned BKW       = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [BKW-1:0]                      wr_bank_i,
  input  logic [AW-1:0]                       wr_addr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic [BW-1:0]                       wr_be_i,
  input  logic [N_BANKS-1:0]                  rd_req_valid_i,
  output logic [N_BANKS-1:0]                  rd_req_ready_o,
  input  logic [N_BANKS-1:0][AW-1:0]          rd_addr_i,
  output logic [N_BANKS-1:0]                  rd_valid_o,
  input  logic [N_BANKS-1:0]                  rd_ready_i,
  output logic [N_BANKS-1:0][DATA_WIDTH-1:0]  rd_data_o,
  output logic [N_BANKS-1:0]                  parity_err_o
);

`ifdef WEIGHTMEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + BW;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif
  localparam int unsigned CW = $clog2(WEIGHTMEM_FIFO_DEPTH + 1);

  if (DATA_WIDTH % 8 != 0) begin : g_width_check
    $error("weightmem_banked: DATA_WIDTH must be a multiple of 8");
  end

  logic                          wr_bank_ok;
  logic                          wr_addr_ok;
  logic                          wr_fire;
  logic [N_BANKS-1:0]            rd_fire;
  logic [N_BANKS-1:0]            rd_addr_ok;
  logic [N_BANKS-1:0][CW-1:0]    fifo_count;

  // Read wins the bank; an out-of-range bank never blocks and is simply dropped.
  always_comb begin
    wr_bank_ok = 32'(wr_bank_i) < N_BANKS;
    wr_addr_ok = 32'(wr_addr_i) < NUM_WORDS;
    wr_ready_o = 1'b1;
    if (wr_bank_ok && rd_req_valid_i[wr_bank_i] && rd_req_ready_o[wr_bank_i])
      wr_ready_o = 1'b0;
    wr_fire = wr_valid_i && wr_ready_o;
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] mem [NUM_WORDS];
    logic [WORD_W-1:0] rword;
    logic              we;

    // No separate SRAM output register: the FIFO entry written at the accept
    // edge is the sampled word, so credit is just the FIFO occupancy.
    assign rd_req_ready_o[b] = fifo_count[b] < CW'(WEIGHTMEM_FIFO_DEPTH);
    assign rd_addr_ok[b]     = 32'(rd_addr_i[b]) < NUM_WORDS;
    assign rd_fire[b]        = rd_req_valid_i[b] && rd_req_ready_o[b];
    assign we                = wr_fire && wr_bank_ok && wr_addr_ok && (wr_bank_i == BKW'(b));
    assign rword             = rd_addr_ok[b] ? mem[rd_addr_i[b]] : '0;

    always_ff @(posedge clk_i) begin
      if (we) begin
        for (int unsigned k = 0; k < BW; k++) begin
          if (wr_be_i[k]) begin
            mem[wr_addr_i][k*8 +: 8] <= wr_data_i[k*8 +: 8];
`ifdef WEIGHTMEM_PARITY_EN
            mem[wr_addr_i][DATA_WIDTH + k] <= even_parity(wr_data_i[k*8 +: 8]);
`endif
          end
        end
      end
    end

    weightmem_rd_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (WEIGHTMEM_FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .push      (rd_fire[b]),
      .push_data (rword[DATA_WIDTH-1:0]),
      .pop       (rd_ready_i[b]),
      .pop_data  (rd_data_o[b]),
      .valid     (rd_valid_o[b]),
      .count     (fifo_count[b])
    );

`ifdef WEIGHTMEM_PARITY_EN
    logic bad;
    logic err;

    always_comb begin
      bad = 1'b0;
      for (int unsigned k = 0; k < BW; k++)
        bad = bad | (even_parity(rword[k*8 +: 8]) ^ rword[DATA_WIDTH + k]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                err <= 1'b0;
      else if (rd_fire[b] && bad) err <= 1'b1;
    end

    assign parity_err_o[b] = err;
`else
    assign parity_err_o[b] = 1'b0;
`endif

    a_rd_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rd_fire[b] |-> rd_addr_ok[b])
      else $error("weightmem_banked: read address out of range on bank %0d", b);
  end

  a_wr_bank: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_fire |-> wr_bank_ok)
    else $error("weightmem_banked: write to nonexistent bank");

  a_wr_addr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wr_fire |-> wr_addr_ok)
    else $error("weightmem_banked: write address out of range");

endmodule
